// File: rtl/c_join_sync.sv
// Synchronous 4-phase join: waits for every enabled input request, forwards one joined request.
// Optional watchdog on REQ/REL enabled by defining C_JOIN_TIMEOUT_EN.
module c_join_sync #(
    parameter int IN_NUM   = 2,
    parameter int TO_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_NUM-1:0] en_mask,
    input  logic [IN_NUM-1:0] in_req,
    output logic [IN_NUM-1:0] in_ack,
    output logic              out_req,
    input  logic              out_ack,
    output logic              busy
`ifdef C_JOIN_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_REL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IN_NUM-1:0] act_mask_q, act_mask_d;
    logic [IN_NUM-1:0] in_ack_q, in_ack_d;
    logic              out_req_q, out_req_d;
    logic              busy_q, busy_d;
    logic              join_ok_s;
    logic              released_s;
    logic              expired_s;

`ifdef C_JOIN_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`endif

    assign join_ok_s  = (en_mask != {IN_NUM{1'b0}}) && ((in_req & en_mask) == en_mask);
    assign released_s = ((in_req & act_mask_q) == {IN_NUM{1'b0}});

`ifdef C_JOIN_TIMEOUT_EN
    assign expired_s = timeout_q;
`else
    assign expired_s = 1'b0;
`endif

    // Next-state, latched mask and registered output values derived from the next state
    always_comb begin
        state_d    = state_q;
        act_mask_d = act_mask_q;
        unique case (state_q)
            S_IDLE: begin
                if (!expired_s && join_ok_s) begin
                    state_d    = S_REQ;
                    act_mask_d = en_mask;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (out_ack)        state_d = S_ACK;
                else if (expired_s) state_d = S_IDLE;
                else                state_d = S_REQ;
            end
            S_ACK: begin
                if (released_s) state_d = S_REL;
                else            state_d = S_ACK;
            end
            S_REL: begin
                if (!out_ack)       state_d = S_IDLE;
                else if (expired_s) state_d = S_IDLE;
                else                state_d = S_REL;
            end
            default: state_d = S_IDLE;
        endcase

        out_req_d = (state_d == S_REQ) || (state_d == S_ACK);
        busy_d    = (state_d != S_IDLE);
        if ((state_d == S_ACK) || (state_d == S_REL)) in_ack_d = act_mask_d;
        else                                          in_ack_d = {IN_NUM{1'b0}};
    end

`ifdef C_JOIN_TIMEOUT_EN
    // Watchdog counts dwell cycles in REQ/REL; any state change restarts it
    always_comb begin
        cnt_d     = 16'd0;
        timeout_d = timeout_q;
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if ((state_q == S_REQ) || (state_q == S_REL)) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_d == 16'(TO_LIMIT)) timeout_d = 1'b1;
            else                        timeout_d = timeout_q;
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    // State, mask and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            act_mask_q <= {IN_NUM{1'b0}};
            in_ack_q   <= {IN_NUM{1'b0}};
            out_req_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_mask_q <= act_mask_d;
            in_ack_q   <= in_ack_d;
            out_req_q  <= out_req_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ack  = in_ack_q;
    assign out_req = out_req_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_c_join_sync.sv
// Directed self-checking bench for c_join_sync (IN_NUM=3, TO_LIMIT=4).
module tb_c_join_sync;

    logic       clk;
    logic       rst;
    logic [2:0] en_mask;
    logic [2:0] in_req;
    logic [2:0] in_ack;
    logic       out_req;
    logic       out_ack;
    logic       busy;
`ifdef C_JOIN_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

    c_join_sync #(.IN_NUM(3), .TO_LIMIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en_mask (en_mask),
        .in_req  (in_req),
        .in_ack  (in_ack),
        .out_req (out_req),
        .out_ack (out_ack),
        .busy    (busy)
`ifdef C_JOIN_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_mask = 3'b000; in_req = 3'b000; out_ack = 1'b0;
        tick(); tick();
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL reset_out_req got %b want 0", out_req); end
        checks++; if (in_ack !== 3'b000) begin errors++; $display("FAIL reset_in_ack got %b want 000", in_ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef C_JOIN_TIMEOUT_EN
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        en_mask = 3'b111; in_req = 3'b000; tick();
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", out_req); end
        in_req = 3'b011; tick();
        checks++; if ({busy, out_req} !== 2'b00) begin errors++; $display("FAIL basic_partial got %b want 00", {busy, out_req}); end
        in_req = 3'b111; tick();
        checks++; if ({busy, out_req, in_ack} !== 5'b11000) begin errors++; $display("FAIL basic_req got %b want 11000", {busy, out_req, in_ack}); end
        out_ack = 1'b1; tick();
        checks++; if ({out_req, in_ack} !== 4'b1111) begin errors++; $display("FAIL basic_ack got %b want 1111", {out_req, in_ack}); end
        in_req = 3'b000; tick();
        checks++; if ({busy, out_req, in_ack} !== 5'b10111) begin errors++; $display("FAIL basic_rel got %b want 10111", {busy, out_req, in_ack}); end
        out_ack = 1'b0; tick();
        checks++; if ({busy, out_req, in_ack} !== 5'b00000) begin errors++; $display("FAIL basic_done got %b want 00000", {busy, out_req, in_ack}); end
    endtask

    task automatic test_mask();
        en_mask = 3'b101; in_req = 3'b101; tick();
        checks++; if ({out_req, in_ack} !== 4'b1000) begin errors++; $display("FAIL mask_req got %b want 1000", {out_req, in_ack}); end
        out_ack = 1'b1; tick();
        checks++; if (in_ack !== 3'b101) begin errors++; $display("FAIL mask_ack got %b want 101", in_ack); end
        in_req = 3'b010; tick();
        checks++; if ({out_req, in_ack} !== 4'b0101) begin errors++; $display("FAIL mask_rel got %b want 0101", {out_req, in_ack}); end
        in_req = 3'b000; out_ack = 1'b0; tick();
        checks++; if ({busy, in_ack} !== 4'b0000) begin errors++; $display("FAIL mask_done got %b want 0000", {busy, in_ack}); end
    endtask

    task automatic test_hold();
        en_mask = 3'b111; in_req = 3'b011; tick();
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL hold_011 got %b want 0", out_req); end
        in_req = 3'b001; tick();
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL hold_001 got %b want 0", out_req); end
        in_req = 3'b110; tick();
        checks++; if (out_req !== 1'b0) begin errors++; $display("FAIL hold_no_memory got %b want 0", out_req); end
        in_req = 3'b111; tick();
        checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL hold_111 got %b want 1", out_req); end
        en_mask = 3'b001; out_ack = 1'b1; tick();
        checks++; if (in_ack !== 3'b111) begin errors++; $display("FAIL hold_mask_change got %b want 111", in_ack); end
        in_req = 3'b110; tick();
        checks++; if (out_req !== 1'b1) begin errors++; $display("FAIL hold_partial_release got %b want 1", out_req); end
        in_req = 3'b000; tick();
        out_ack = 1'b0; tick();
        checks++; if ({busy, in_ack} !== 4'b0000) begin errors++; $display("FAIL hold_done got %b want 0000", {busy, in_ack}); end
    endtask

    task automatic test_rst_mid();
        en_mask = 3'b111; in_req = 3'b111; tick();
        out_ack = 1'b1; tick();
        checks++; if (in_ack !== 3'b111) begin errors++; $display("FAIL rstmid_ack got %b want 111", in_ack); end
        rst = 1'b1; tick();
        checks++; if ({busy, out_req, in_ack} !== 5'b00000) begin errors++; $display("FAIL rstmid_abort got %b want 00000", {busy, out_req, in_ack}); end
        rst = 1'b0; out_ack = 1'b0; tick();
        checks++; if ({busy, out_req, in_ack} !== 5'b11000) begin errors++; $display("FAIL rstmid_restart got %b want 11000", {busy, out_req, in_ack}); end
        out_ack = 1'b1; tick();
        in_req = 3'b000; tick();
        out_ack = 1'b0; tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", busy); end
    endtask

    task automatic test_disabled();
        en_mask = 3'b000; in_req = 3'b111;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if ({busy, out_req} !== 2'b00) begin errors++; $display("FAIL disabled_c%0d got %b want 00", i, {busy, out_req}); end
        end
        in_req = 3'b000;
    endtask

`ifdef C_JOIN_TIMEOUT_EN
    task automatic test_timeout();
        en_mask = 3'b111; in_req = 3'b111; out_ack = 1'b0; tick();
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if ({timeout, out_req} !== 2'b01) begin errors++; $display("FAIL to_wait_c%0d got %b want 01", i, {timeout, out_req}); end
        end
        tick();
        checks++; if ({timeout, busy} !== 2'b11) begin errors++; $display("FAIL to_set got %b want 11", {timeout, busy}); end
        tick();
        checks++; if ({timeout, busy, out_req, in_ack} !== 6'b100000) begin errors++; $display("FAIL to_idle got %b want 100000", {timeout, busy, out_req, in_ack}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({busy, out_req} !== 2'b00) begin errors++; $display("FAIL to_ignored_c%0d got %b want 00", i, {busy, out_req}); end
        end
        rst = 1'b1; in_req = 3'b000; tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", timeout); end
        rst = 1'b0; tick();
    endtask
`else
    task automatic test_no_timeout();
        en_mask = 3'b111; in_req = 3'b111; out_ack = 1'b0; tick();
        for (int i = 0; i < 20; i++) tick();
        checks++; if ({busy, out_req} !== 2'b11) begin errors++; $display("FAIL no_to_wait got %b want 11", {busy, out_req}); end
        out_ack = 1'b1; tick();
        in_req = 3'b000; tick();
        out_ack = 1'b0; tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL no_to_done got %b want 0", busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_hold();
        test_rst_mid();
        test_disabled();
`ifdef C_JOIN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
